fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the forwarding pipeline. It owns the PC, drives the instruction-memory address, and latches the fetched word into `ir`, which feeds the decode controller directly. It applies hazard-unit stalls, EX-stage redirects (taken branch/jump flush) and syscall halt. It also keeps fetch and stall performance counters.

## Interface
- `PC_RESET`, default 32'h0000_0000: PC value after reset; bits [1:0] must be 0.
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `stall`  in  1  load-use stall from the hazard unit: hold PC and IF/ID.
- `redirect`  in  1  taken branch/jump resolved in EX: flush IF/ID and load the PC.
- `redirect_pc`  in  32  redirect target; bits [1:0] are ignored and treated as 00.
- `go`  in  1  resume fetch from HALT.
- `imem_addr`  out  32  byte address to instruction memory; always equals `pc`.
- `imem_rdata`  in  32  instruction word; combinational read of `imem_addr` in the same cycle.
- `ir`  out  32  IF/ID instruction register, consumed by the decode controller.
- `id_pc`  out  32  PC of the instruction in `ir`.
- `id_pc4`  out  32  `id_pc` + 4, used for link and branch-base computation.
- `id_valid`  out  1  `ir` holds a real instruction (0 = bubble).
- `halted`  out  1  state is HALT.
- `fetch_cnt`  out  32  count of valid instructions latched into IF/ID.
- `stall_cnt`  out  32  count of stall cycles.

## Operation
- State machine: RUN, HALT.
- Reset (asynchronous, any time, including mid-stall or mid-redirect):
  - state = RUN; pc = `PC_RESET`.
  - `ir` = 0 (sll $0 NOP); `id_pc` = 0; `id_pc4` = 0; `id_valid` = 0.
  - `halted` = 0; `fetch_cnt` = 0; `stall_cnt` = 0.
- Per-edge priority: `redirect` > `stall` > normal. `go` is evaluated only in HALT.
- Redirect (either state):
  - pc <= {`redirect_pc`[31:2], 2'b00}.
  - IF/ID <= bubble (`ir` = 0, `id_valid` = 0; `id_pc` and `id_pc4` hold).
  - state <= RUN.
  - Redirect overrides a simultaneous `stall`, and also overrides the syscall halt: an older branch squashes the syscall.
- Stall without redirect: pc and all IF/ID fields hold.
  - In RUN, `stall_cnt` += 1.
  - In HALT, `stall_cnt` does not count.
- Normal in RUN:
  - IF/ID <= {`imem_rdata`, pc, pc+4, valid = 1}; pc <= pc+4; `fetch_cnt` += 1.
  - If the latched word is syscall (op = 6'b000000, funct = 6'b001100), state <= HALT.
- Normal in HALT:
  - pc holds; IF/ID <= bubble; counters hold.
  - If `go` = 1, state <= RUN and fetch resumes at the held pc on the next edge.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0). Both counters wrap modulo 2^32.
- `halted` is a direct decode of the state register.

## Timing
- Fetch latency is 1 cycle: the word at pc appears on `ir` after the next rising edge.
- Redirect asserted in cycle N:
  - `imem_addr` = target in N+1.
  - Bubble on `ir` in N+1.
  - Target instruction on `ir` in N+2.
- Stall asserted for k cycles delays `ir` advance by exactly k cycles; no instruction is lost or duplicated.
- Syscall latched at edge N:
  - `halted` = 1 from N.
  - Bubbles on `ir` from edge N+1 onward.
  - pc = syscall pc + 4 from N.
- `go` sampled at edge M (in HALT):
  - RUN from M.
  - Instruction at syscall pc + 4 on `ir` after edge M+1.
- `redirect` and `stall` are sampled only at rising edges; they are assumed stable at the edge and are never treated as level-triggered between edges.

## Test plan
- Reset release, straight-line code at 0,4,8: `ir` shows words 0,4,8 on consecutive cycles; `id_pc` = 0,4,8; `fetch_cnt` = 3.
- `stall` held 2 cycles with pc = 8: `ir` and `id_pc` hold at 4; `imem_addr` holds at 8; `stall_cnt` = 2; word at 8 follows with no loss.
- `redirect` = 1 with `redirect_pc` = 32'h0000_0103 and `stall` = 1 at the same edge: `imem_addr` = 32'h100 next cycle, one bubble (`id_valid` = 0), then word at 0x100; `stall_cnt` unchanged.
- Syscall word 32'h0000_000C at pc 0x20: `halted` = 1, pc = 0x24, bubbles for 5 cycles; `go` pulse, then word at 0x24 appears two edges later.
- Syscall latched and `redirect` to 0x40 at the next edge: `halted` returns to 0 and word at 0x40 is fetched; `rst` pulsed mid-stream between edges: all outputs return to reset values immediately.
- PC_RESET = 32'hFFFF_FFFC: second fetch address wraps to 0.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, drives the instruction-memory address and
// registers the fetched word into the IF/ID register feeding decode.
// Handles hazard stalls, EX-stage redirects (flush) and syscall halt,
// and keeps fetch/stall performance counters.
module fetch_stage #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        go,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ir,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc4,
   output logic        id_valid,
   output logic        halted,
   output logic [31:0] fetch_cnt,
   output logic [31:0] stall_cnt
);

   typedef enum logic {
      S_RUN  = 1'b0,
      S_HALT = 1'b1
   } state_t;

   // all-zero word is sll $0,$0,0, which decode treats as a NOP
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   // PC is word aligned by construction; force the low bits clear so a
   // misaligned reset parameter cannot leak into the address bus
   localparam logic [31:0] PC_INIT = {PC_RESET[31:2], 2'b00};

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_pc4_q, id_pc4_d;
   logic        id_valid_q, id_valid_d;
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   logic [31:0] pc_plus4;
   logic [31:0] redirect_target;
   logic        fetch_is_syscall;
   logic [1:0]  unused_redirect_lsb;

   // SPECIAL opcode with funct 001100 is syscall; other fields are don't-care
   function automatic logic is_syscall(input logic [31:0] word);
      return (word[31:26] == 6'b000000) && (word[5:0] == 6'b001100);
   endfunction

   // sequential next PC, wraps naturally at 2^32
   function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

   assign pc_plus4            = next_seq_pc(pc_q);
   assign redirect_target     = {redirect_pc[31:2], 2'b00};
   assign unused_redirect_lsb = redirect_pc[1:0];
   assign fetch_is_syscall    = is_syscall(imem_rdata);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: redirect always wins, stall freezes, otherwise run/halt rules
   always_comb begin
      state_d = state_q;
      if (redirect) begin
         // an older branch squashes any syscall being latched this edge
         state_d = S_RUN;
      end else if (!stall) begin
         case (state_q)
            S_RUN: begin
               if (fetch_is_syscall) begin
                  state_d = S_HALT;
               end
            end
            S_HALT: begin
               if (go) begin
                  state_d = S_RUN;
               end
            end
         endcase
      end
   end

   // Outputs decoded from the state register
   always_comb begin
      halted = (state_q == S_HALT);
   end

   // PC, IF/ID and counter next values
   always_comb begin
      pc_d        = pc_q;
      ir_d        = ir_q;
      id_pc_d     = id_pc_q;
      id_pc4_d    = id_pc4_q;
      id_valid_d  = id_valid_q;
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;

      if (redirect) begin
         // flush: bubble into IF/ID, id_pc/id_pc4 keep their old values
         pc_d       = redirect_target;
         ir_d       = NOP_WORD;
         id_valid_d = 1'b0;
      end else if (stall) begin
         // hold everything; only a stall while running is a lost fetch slot
         if (state_q == S_RUN) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
         end
      end else if (state_q == S_RUN) begin
         ir_d        = imem_rdata;
         id_pc_d     = pc_q;
         id_pc4_d    = pc_plus4;
         id_valid_d  = 1'b1;
         pc_d        = pc_plus4;
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      end else begin
         // halted: PC parks on syscall pc + 4, decode sees bubbles
         ir_d       = NOP_WORD;
         id_valid_d = 1'b0;
      end
   end

   // PC, IF/ID and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q        <= PC_INIT;
         ir_q        <= NOP_WORD;
         id_pc_q     <= 32'h0000_0000;
         id_pc4_q    <= 32'h0000_0000;
         id_valid_q  <= 1'b0;
         fetch_cnt_q <= 32'h0000_0000;
         stall_cnt_q <= 32'h0000_0000;
      end else begin
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         id_pc_q     <= id_pc_d;
         id_pc4_q    <= id_pc4_d;
         id_valid_q  <= id_valid_d;
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign imem_addr = pc_q;
   assign ir        = ir_q;
   assign id_pc     = id_pc_q;
   assign id_pc4    = id_pc4_q;
   assign id_valid  = id_valid_q;
   assign fetch_cnt = fetch_cnt_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized stall/redirect/go
// traffic, checked every cycle against a behavioural fetch model.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        go = 1'b0;

   logic [31:0] imem_addr, imem_rdata, ir, id_pc, id_pc4, fetch_cnt, stall_cnt;
   logic        id_valid, halted;

   logic [31:0] w_imem_addr, w_imem_rdata, w_ir, w_id_pc, w_id_pc4, w_fetch_cnt, w_stall_cnt;
   logic        w_id_valid, w_halted;

   int n_chk  = 0;
   int n_fail = 0;

   // Instruction memory: syscall at 0x20 and at every 32nd word of the
   // 0x0001_xxxx region, otherwise a distinct lw whose low bits encode the address
   function automatic logic [31:0] word_at(input logic [31:0] a);
      if (a == 32'h0000_0020 || (a[31:16] == 16'h0001 && a[6:2] == 5'd7))
         return 32'h0000_000C;
      return {6'h23, a[27:2]};
   endfunction

   assign imem_rdata   = word_at(imem_addr);
   assign w_imem_rdata = word_at(w_imem_addr);

   fetch_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .go(go), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .ir(ir), .id_pc(id_pc), .id_pc4(id_pc4),
      .id_valid(id_valid), .halted(halted), .fetch_cnt(fetch_cnt),
      .stall_cnt(stall_cnt)
   );

   fetch_stage #(.PC_RESET(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .go(go), .imem_addr(w_imem_addr),
      .imem_rdata(w_imem_rdata), .ir(w_ir), .id_pc(w_id_pc), .id_pc4(w_id_pc4),
      .id_valid(w_id_valid), .halted(w_halted), .fetch_cnt(w_fetch_cnt),
      .stall_cnt(w_stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_pc = 32'h0, m_ir = 32'h0, m_id_pc = 32'h0, m_id_pc4 = 32'h0;
   logic [31:0] m_fc = 32'h0, m_sc = 32'h0;
   logic        m_valid = 1'b0, m_halt = 1'b0;

   task automatic model_step();
      if (rst) begin
         m_pc = 32'h0; m_ir = 32'h0; m_id_pc = 32'h0; m_id_pc4 = 32'h0;
         m_valid = 1'b0; m_halt = 1'b0; m_fc = 32'h0; m_sc = 32'h0;
      end else if (redirect) begin
         m_pc    = redirect_pc & 32'hFFFF_FFFC;
         m_ir    = 32'h0;
         m_valid = 1'b0;
         m_halt  = 1'b0;
      end else if (stall) begin
         if (!m_halt) m_sc = m_sc + 1;
      end else if (!m_halt) begin
         m_ir     = word_at(m_pc);
         m_id_pc  = m_pc;
         m_id_pc4 = m_pc + 4;
         m_valid  = 1'b1;
         m_pc     = m_pc + 4;
         m_fc     = m_fc + 1;
         if (m_ir[31:26] == 6'd0 && m_ir[5:0] == 6'd12) m_halt = 1'b1;
      end else begin
         m_ir    = 32'h0;
         m_valid = 1'b0;
         if (go) m_halt = 1'b0;
      end
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      model_step();
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      chk("m_imem_addr", imem_addr, m_pc);
      chk("m_ir", ir, m_ir);
      chk("m_id_pc", id_pc, m_id_pc);
      chk("m_id_pc4", id_pc4, m_id_pc4);
      chk("m_id_valid", {31'b0, id_valid}, {31'b0, m_valid});
      chk("m_halted", {31'b0, halted}, {31'b0, m_halt});
      chk("m_fetch_cnt", fetch_cnt, m_fc);
      chk("m_stall_cnt", stall_cnt, m_sc);
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   initial begin
      // reset state
      tick(); tick();
      chk("rst_ir", ir, 32'h0);
      chk("rst_id_valid", {31'b0, id_valid}, 32'h0);
      chk("rst_halted", {31'b0, halted}, 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("w_rst_addr", w_imem_addr, 32'hFFFF_FFFC);
      rst = 1'b0;

      // straight-line fetch at 0, 4
      tick();
      chk("f0_ir", ir, 32'h8C00_0000);
      chk("f0_id_pc", id_pc, 32'h0);
      chk("w_wrap_addr", w_imem_addr, 32'h0);
      chk("w_wrap_id_pc", w_id_pc, 32'hFFFF_FFFC);
      chk("w_wrap_id_pc4", w_id_pc4, 32'h0);
      chk("w_wrap_ir", w_ir, 32'h8FFF_FFFF);
      tick();
      chk("f1_ir", ir, 32'h8C00_0001);
      chk("f1_id_pc4", id_pc4, 32'h8);

      // stall two cycles at pc = 8
      stall = 1'b1;
      tick(); tick();
      stall = 1'b0;
      chk("st_ir", ir, 32'h8C00_0001);
      chk("st_id_pc", id_pc, 32'h4);
      chk("st_addr", imem_addr, 32'h8);
      chk("st_cnt", stall_cnt, 32'd2);
      tick();
      chk("st_after_ir", ir, 32'h8C00_0002);
      chk("st_after_id_pc", id_pc, 32'h8);
      chk("fetch_cnt3", fetch_cnt, 32'd3);

      // redirect with simultaneous stall
      redirect = 1'b1; redirect_pc = 32'h0000_0103; stall = 1'b1;
      tick();
      redirect = 1'b0; stall = 1'b0;
      chk("rd_addr", imem_addr, 32'h100);
      chk("rd_bubble", {31'b0, id_valid}, 32'h0);
      chk("rd_ir", ir, 32'h0);
      chk("rd_stall_cnt", stall_cnt, 32'd2);
      tick();
      chk("rd_tgt_ir", ir, 32'h8C00_0040);
      chk("rd_tgt_id_pc", id_pc, 32'h100);

      // syscall at 0x20, halt, bubbles, go
      redirect = 1'b1; redirect_pc = 32'h20;
      tick();
      redirect = 1'b0;
      tick();
      chk("sc_halted", {31'b0, halted}, 32'h1);
      chk("sc_ir", ir, 32'h0000_000C);
      chk("sc_pc", imem_addr, 32'h24);
      for (int i = 0; i < 5; i++) begin
         stall = (i == 1 || i == 2);
         tick();
         chk("hl_valid", {31'b0, id_valid}, 32'h0);
         chk("hl_halted", {31'b0, halted}, 32'h1);
         chk("hl_pc", imem_addr, 32'h24);
      end
      stall = 1'b0;
      chk("hl_stall_cnt", stall_cnt, 32'd2);
      go = 1'b1;
      tick();
      go = 1'b0;
      chk("go_run", {31'b0, halted}, 32'h0);
      chk("go_bubble", {31'b0, id_valid}, 32'h0);
      tick();
      chk("go_ir", ir, 32'h8C00_0009);
      chk("go_id_pc", id_pc, 32'h24);

      // syscall squashed by redirect on the next edge
      redirect = 1'b1; redirect_pc = 32'h20;
      tick();
      redirect = 1'b0;
      tick();
      chk("sq_halted", {31'b0, halted}, 32'h1);
      redirect = 1'b1; redirect_pc = 32'h40;
      tick();
      redirect = 1'b0;
      chk("sq_run", {31'b0, halted}, 32'h0);
      chk("sq_addr", imem_addr, 32'h40);
      tick();
      chk("sq_ir", ir, 32'h8C00_0010);
      tick();

      // asynchronous reset between edges
      rst = 1'b1;
      #1;
      chk("ar_addr", imem_addr, 32'h0);
      chk("ar_ir", ir, 32'h0);
      chk("ar_id_pc", id_pc, 32'h0);
      chk("ar_id_pc4", id_pc4, 32'h0);
      chk("ar_valid", {31'b0, id_valid}, 32'h0);
      chk("ar_fetch_cnt", fetch_cnt, 32'h0);
      chk("ar_stall_cnt", stall_cnt, 32'h0);
      #1;
      rst = 1'b0;

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         stall       = ($urandom % 5) == 0;
         redirect    = ($urandom % 12) == 0;
         redirect_pc = {16'h0001, 6'b0, 10'($urandom)};
         go          = ($urandom % 3) == 0;
         if (($urandom % 400) == 0) begin
            rst = 1'b1;
            #1;
            rst = 1'b0;
         end
         tick();
      end

      stall = 1'b0; redirect = 1'b0; go = 1'b0;
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
